// File: rtl/fb_sched_pkg.sv
// Shared types for the triple-buffer frame scheduler.
//   NUM_BUFS   : number of frame buffers rotated between writer and reader
//   buf_idx_t  : 2-bit buffer index
//   wr_state_e : writer FSM states
package fb_sched_pkg;

    localparam int NUM_BUFS = 3;

    typedef logic [1:0] buf_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_WRITING = 2'd2
    } wr_state_e;

endpackage

// File: rtl/fb_triple_sched_if.sv
// Writer/reader handshake bundle of the triple-buffer scheduler.
//   master : scheduler side (drives wr_dma_start, addresses, rd_buf_valid)
//   slave  : writer DMA / display reader side (drives frame pulses)
interface fb_triple_sched_if #(
    parameter int ADDR_WIDTH = 24
);
    logic                  wr_frame_start;
    logic                  wr_frame_done;
    logic                  wr_dma_start;
    logic [ADDR_WIDTH-1:0] wr_base_addr;
    logic                  rd_frame_req;
    logic [ADDR_WIDTH-1:0] rd_base_addr;
    logic                  rd_buf_valid;

    modport master (
        input  wr_frame_start, wr_frame_done, rd_frame_req,
        output wr_dma_start, wr_base_addr, rd_base_addr, rd_buf_valid
    );

    modport slave (
        output wr_frame_start, wr_frame_done, rd_frame_req,
        input  wr_dma_start, wr_base_addr, rd_base_addr, rd_buf_valid
    );
endinterface

// File: rtl/fb_sat_cnt.sv
// Saturating up-counter: counts inc_i pulses, sticks at all-ones.
//   clk_sys, rst_sys_n : clock, async active-low reset (clears to 0)
//   inc_i              : increment request for this cycle
//   cnt_o              : current count
module fb_sat_cnt #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_sys,
    input  logic                 rst_sys_n,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) cnt_q <= '0;
        else            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/fb_triple_sched.sv
// Triple-buffer frame scheduler between a writer DMA and a display reader.
// Writer index W, latest-complete index L and reader index R always hold
// the three distinct buffers 0..2.
//   clk_sys, rst_sys_n   : clock, async active-low reset
//   cfg_enable           : run enable; low returns to idle with reset indices
//   cfg_base_addr        : address of buffer 0
//   cfg_frame_stride     : byte distance between buffers
//   bus (master)         : frame start/done/req in; dma start, addresses,
//                          rd_buf_valid out
//   stat_dropped         : completed frames overwritten before being read
//   stat_sync_err        : frame starts seen while already writing
//   stat_wr_idx/rd_idx   : current writer / reader buffer index
module fb_triple_sched
    import fb_sched_pkg::*;
#(
    parameter int ADDR_WIDTH = 24,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_sys,
    input  logic                  rst_sys_n,
    input  logic                  cfg_enable,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_frame_stride,
    fb_triple_sched_if.master     bus,
    output logic [CNT_WIDTH-1:0]  stat_dropped,
    output logic [CNT_WIDTH-1:0]  stat_sync_err,
    output buf_idx_t              stat_wr_idx,
    output buf_idx_t              stat_rd_idx
);
    localparam buf_idx_t W_RST = 2'd0;
    localparam buf_idx_t L_RST = 2'd1;
    localparam buf_idx_t R_RST = 2'd2;

    function automatic logic [ADDR_WIDTH-1:0] buf_addr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [ADDR_WIDTH-1:0] stride,
        input buf_idx_t              idx
    );
        return base + stride * {{(ADDR_WIDTH-2){1'b0}}, idx};
    endfunction

    wr_state_e             st_q, st_d;
    buf_idx_t              w_q, w_d, l_q, l_d, r_q, r_d;
    logic                  rdy_q, rdy_d;
    logic                  vld_q, vld_d;
    logic                  dma_q, dma_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d, ra_q, ra_d;
    logic                  drop_inc, sync_inc;

    always_comb begin
        st_d     = st_q;
        w_d      = w_q;
        l_d      = l_q;
        r_d      = r_q;
        rdy_d    = rdy_q;
        vld_d    = vld_q;
        dma_d    = 1'b0;
        wa_d     = wa_q;
        ra_d     = ra_q;
        drop_inc = 1'b0;
        sync_inc = 1'b0;

        if (!cfg_enable) begin
            // IDLE is only ever entered with reset indices, so nothing to redo there
            if (st_q != ST_IDLE) begin
                st_d  = ST_IDLE;
                w_d   = W_RST;
                l_d   = L_RST;
                r_d   = R_RST;
                rdy_d = 1'b0;
                vld_d = 1'b0;
                wa_d  = buf_addr(cfg_base_addr, cfg_frame_stride, W_RST);
                ra_d  = buf_addr(cfg_base_addr, cfg_frame_stride, R_RST);
            end
        end else begin
            unique case (st_q)
                ST_IDLE: begin
                    // enable latches the current address config
                    st_d = ST_ARMED;
                    wa_d = buf_addr(cfg_base_addr, cfg_frame_stride, w_q);
                    ra_d = buf_addr(cfg_base_addr, cfg_frame_stride, r_q);
                end
                ST_ARMED: begin
                    if (bus.wr_frame_start) begin
                        st_d  = ST_WRITING;
                        dma_d = 1'b1;
                    end
                end
                ST_WRITING: begin
                    if (bus.wr_frame_done) begin
                        // The free buffer is always L (indices are a permutation),
                        // so the writer simply trades places with L whether or not
                        // L still holds an unread frame.
                        st_d     = ST_ARMED;
                        l_d      = w_q;
                        w_d      = l_q;
                        rdy_d    = 1'b1;
                        vld_d    = 1'b1;
                        drop_inc = rdy_q;
                        wa_d     = buf_addr(cfg_base_addr, cfg_frame_stride, l_q);
                    end else if (bus.wr_frame_start) begin
                        dma_d    = 1'b1;
                        sync_inc = 1'b1;
                    end
                end
                default: st_d = ST_IDLE;
            endcase

            // Read sees the post-done view, so a coincident done hands the
            // just-finished buffer straight to the reader.
            if ((st_q != ST_IDLE) && bus.rd_frame_req && rdy_d) begin
                r_d   = l_d;
                l_d   = r_q;
                rdy_d = 1'b0;
                ra_d  = buf_addr(cfg_base_addr, cfg_frame_stride, r_d);
            end
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            st_q  <= ST_IDLE;
            w_q   <= W_RST;
            l_q   <= L_RST;
            r_q   <= R_RST;
            rdy_q <= 1'b0;
            vld_q <= 1'b0;
            dma_q <= 1'b0;
            wa_q  <= '0;
            ra_q  <= '0;
        end else begin
            st_q  <= st_d;
            w_q   <= w_d;
            l_q   <= l_d;
            r_q   <= r_d;
            rdy_q <= rdy_d;
            vld_q <= vld_d;
            dma_q <= dma_d;
            wa_q  <= wa_d;
            ra_q  <= ra_d;
        end
    end

    fb_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_drop (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .inc_i     (drop_inc),
        .cnt_o     (stat_dropped)
    );

    fb_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_sync (
        .clk_sys   (clk_sys),
        .rst_sys_n (rst_sys_n),
        .inc_i     (sync_inc),
        .cnt_o     (stat_sync_err)
    );

    assign bus.wr_dma_start = dma_q;
    assign bus.wr_base_addr = wa_q;
    assign bus.rd_base_addr = ra_q;
    assign bus.rd_buf_valid = vld_q;
    assign stat_wr_idx      = w_q;
    assign stat_rd_idx      = r_q;
endmodule

// File: tb/tb_fb_triple_sched.sv
module tb_fb_triple_sched;
    localparam int AW = 24;
    localparam int CW = 4;
    localparam longint CMAX = (longint'(1) << CW) - 1;

    logic          clk_sys = 1'b0;
    logic          rst_sys_n = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [AW-1:0] cfg_base_addr = '0;
    logic [AW-1:0] cfg_frame_stride = '0;
    logic [CW-1:0] stat_dropped, stat_sync_err;
    logic [1:0]    stat_wr_idx, stat_rd_idx;

    fb_triple_sched_if #(.ADDR_WIDTH(AW)) bus ();

    fb_triple_sched #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk_sys          (clk_sys),
        .rst_sys_n        (rst_sys_n),
        .cfg_enable       (cfg_enable),
        .cfg_base_addr    (cfg_base_addr),
        .cfg_frame_stride (cfg_frame_stride),
        .bus              (bus),
        .stat_dropped     (stat_dropped),
        .stat_sync_err    (stat_sync_err),
        .stat_wr_idx      (stat_wr_idx),
        .stat_rd_idx      (stat_rd_idx)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference model: modes 0=idle 1=armed 2=writing; buffers as plain ints.
    int     m_st, m_w, m_l, m_r, n_st, n_w, n_l, n_r;
    bit     m_rdy, m_vld, m_dma, n_rdy, n_vld, n_dma;
    longint m_drop, m_sync, m_wa, m_ra, n_drop, n_sync, n_wa, n_ra;

    function automatic longint addr(input int idx);
        return (longint'(cfg_base_addr) + longint'(idx) * longint'(cfg_frame_stride))
               % (longint'(1) << AW);
    endfunction

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_w = 0; m_l = 1; m_r = 2;
        m_rdy = 0; m_vld = 0; m_dma = 0;
        m_drop = 0; m_sync = 0; m_wa = 0; m_ra = 0;
    endtask

    task automatic model_step(input bit st, input bit dn, input bit rq);
        n_st = m_st; n_w = m_w; n_l = m_l; n_r = m_r;
        n_rdy = m_rdy; n_vld = m_vld; n_dma = 0;
        n_drop = m_drop; n_sync = m_sync; n_wa = m_wa; n_ra = m_ra;
        if (!cfg_enable) begin
            if (m_st != 0) begin
                n_st = 0; n_w = 0; n_l = 1; n_r = 2; n_rdy = 0; n_vld = 0;
                n_wa = addr(0); n_ra = addr(2);
            end
        end else begin
            if (m_st == 0) begin
                n_st = 1; n_wa = addr(m_w); n_ra = addr(m_r);
            end else if (m_st == 1) begin
                if (st) begin n_st = 2; n_dma = 1; end
            end else begin
                if (dn) begin
                    n_st = 1;
                    n_l = m_w;
                    n_w = m_rdy ? m_l : 3 - m_w - m_r;
                    if (m_rdy) n_drop = sat(m_drop + 1);
                    n_rdy = 1; n_vld = 1;
                    n_wa = addr(n_w);
                end else if (st) begin
                    n_dma = 1; n_sync = sat(m_sync + 1);
                end
            end
            if (m_st != 0 && rq && n_rdy) begin
                n_r = n_l;
                n_l = 3 - n_w - n_r;
                n_rdy = 0;
                n_ra = addr(n_r);
            end
        end
    endtask

    task automatic check_all();
        chk("wr_base_addr", longint'(bus.wr_base_addr), m_wa);
        chk("rd_base_addr", longint'(bus.rd_base_addr), m_ra);
        chk("wr_dma_start", longint'(bus.wr_dma_start), longint'(m_dma));
        chk("rd_buf_valid", longint'(bus.rd_buf_valid), longint'(m_vld));
        chk("stat_dropped", longint'(stat_dropped), m_drop);
        chk("stat_sync_err", longint'(stat_sync_err), m_sync);
        chk("stat_wr_idx", longint'(stat_wr_idx), longint'(m_w));
        chk("stat_rd_idx", longint'(stat_rd_idx), longint'(m_r));
    endtask

    task automatic tick(input bit st, input bit dn, input bit rq);
        bus.wr_frame_start = st;
        bus.wr_frame_done  = dn;
        bus.rd_frame_req   = rq;
        model_step(st, dn, rq);
        @(posedge clk_sys);
        #1;
        m_st = n_st; m_w = n_w; m_l = n_l; m_r = n_r;
        m_rdy = n_rdy; m_vld = n_vld; m_dma = n_dma;
        m_drop = n_drop; m_sync = n_sync; m_wa = n_wa; m_ra = n_ra;
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_req   = 1'b0;
        check_all();
    endtask

    task automatic frame();
        tick(1, 0, 0);
        tick(0, 1, 0);
    endtask

    longint saved;
    int     old_w;

    initial begin
        bus.wr_frame_start = 1'b0;
        bus.wr_frame_done  = 1'b0;
        bus.rd_frame_req   = 1'b0;
        model_reset();
        #12;
        chk("rst_wr_idx", longint'(stat_wr_idx), 0);
        chk("rst_rd_idx", longint'(stat_rd_idx), 2);
        chk("rst_wr_addr", longint'(bus.wr_base_addr), 0);
        chk("rst_valid", longint'(bus.rd_buf_valid), 0);
        chk("rst_dropped", longint'(stat_dropped), 0);
        rst_sys_n = 1'b1;
        @(posedge clk_sys); #1;

        // basic frame with reference addresses
        cfg_base_addr = 24'h100000;
        cfg_frame_stride = 24'h0C0000;
        cfg_enable = 1'b1;
        tick(0, 0, 0);
        tick(1, 0, 0);
        chk("dma_pulse", longint'(bus.wr_dma_start), 1);
        chk("dma_addr", longint'(bus.wr_base_addr), 24'h100000);
        tick(0, 0, 0);
        chk("dma_one_cycle", longint'(bus.wr_dma_start), 0);
        tick(0, 1, 0);
        chk("done_wr_idx", longint'(stat_wr_idx), 1);
        chk("done_wr_addr", longint'(bus.wr_base_addr), 24'h1C0000);
        chk("done_valid", longint'(bus.rd_buf_valid), 1);

        // two more frames unread, then read the newest
        frame();
        frame();
        chk("three_frames_dropped", longint'(stat_dropped), 2);
        tick(0, 0, 1);
        chk("read_newest_addr", longint'(bus.rd_base_addr), 24'h100000);
        tick(0, 0, 1);
        chk("read_repeat_addr", longint'(bus.rd_base_addr), 24'h100000);

        // second start while writing
        tick(1, 0, 0);
        tick(1, 0, 0);
        chk("sync_err", longint'(stat_sync_err), 1);
        chk("sync_dma_repulse", longint'(bus.wr_dma_start), 1);
        tick(0, 1, 0);

        // done + read together, ready low then ready high
        tick(0, 0, 1);
        tick(1, 0, 0);
        old_w = m_w;
        saved = m_drop;
        tick(0, 1, 1);
        chk("coinc_rd_idx", longint'(stat_rd_idx), longint'(old_w));
        chk("coinc_no_drop", longint'(stat_dropped), saved);
        frame();
        tick(1, 0, 0);
        saved = m_drop;
        tick(0, 1, 1);
        chk("coinc_drop_inc", longint'(stat_dropped), saved + 1);

        // disable mid-frame, then re-enable
        tick(1, 0, 0);
        saved = m_drop;
        cfg_enable = 1'b0;
        tick(0, 0, 0);
        chk("dis_wr_idx", longint'(stat_wr_idx), 0);
        chk("dis_rd_idx", longint'(stat_rd_idx), 2);
        chk("dis_valid", longint'(bus.rd_buf_valid), 0);
        chk("dis_keep_drop", longint'(stat_dropped), saved);
        cfg_enable = 1'b1;
        tick(0, 0, 0);

        // counter saturation
        for (int i = 0; i < 20; i++) frame();
        chk("drop_saturates", longint'(stat_dropped), CMAX);

        // address wrap mod 2^24
        cfg_frame_stride = 24'h900000;
        cfg_enable = 1'b0;
        tick(0, 0, 0);
        cfg_enable = 1'b1;
        tick(0, 0, 0);
        chk("addr_wrap", longint'(bus.rd_base_addr), 24'h300000);

        // async reset mid-frame
        tick(1, 0, 0);
        #2 rst_sys_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk_sys); #1;
        rst_sys_n = 1'b1;
        tick(0, 0, 0);
        tick(0, 1, 0);
        tick(0, 0, 0);
        chk("no_dma_after_rst", longint'(bus.wr_dma_start), 0);
        tick(1, 0, 0);
        chk("dma_after_rst_start", longint'(bus.wr_dma_start), 1);

        // randomized traffic against the model
        cfg_frame_stride = 24'h0C0000;
        for (int i = 0; i < 800; i++) begin
            int ev;
            cfg_enable = ($urandom_range(0, 40) != 0);
            if ($urandom_range(0, 63) == 0) begin
                cfg_base_addr = AW'($urandom);
                cfg_frame_stride = AW'($urandom);
            end
            ev = $urandom_range(0, 3);
            tick(ev == 1, ev == 2, $urandom_range(0, 2) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
